// File: rtl/sopc_reset_sequencer.sv
// sopc_reset_sequencer
//   Power-on / external / software reset controller for the openmips SOPC.
//   Holds every domain reset for HOLD_CYCLES after a synchronised release,
//   releases domain 0 first and then one domain every STAGE_GAP cycles,
//   then runs a RUN_CYCLES watchdog that raises a sticky expiry flag.
//
//   Optional build macro: RSTSEQ_EXPIRE_RESTART_EN
//     defined   : watchdog expiry re-asserts all domains and replays the full
//                 release sequence (expiry flag stays set).
//     undefined : expiry only raises the flag; domains keep running.
module sopc_reset_sequencer #(
   parameter int NUM_DOMAINS = 2,
   parameter int HOLD_CYCLES = 10,
   parameter int STAGE_GAP   = 4,
   parameter int RUN_CYCLES  = 50,
   parameter int CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ext_rst_req,
   input  logic                   sw_rst_pulse,
   output logic [NUM_DOMAINS-1:0] dom_rst_o,
   output logic                   all_released_o,
   output logic                   run_expired_o,
   output logic [1:0]             state_o
);

   // stage_idx only has to name domains 1..NUM_DOMAINS-1
   localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_DOM  = IDX_W'(NUM_DOMAINS - 1);

   typedef enum logic [1:0] {
      S_HOLD    = 2'd0,
      S_STAGE   = 2'd1,
      S_RUN     = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;

   state_t                 state, state_n;
   logic [CNT_W-1:0]       hold_cnt, hold_n;
   logic [CNT_W-1:0]       gap_cnt, gap_n;
   logic [CNT_W-1:0]       run_cnt, run_n;
   logic [IDX_W-1:0]       stage_idx, idx_n;
   logic [NUM_DOMAINS-1:0] dom_rst, dom_n;
   logic                   all_rel, all_n;
   logic                   run_exp, exp_n;
   // One idle HOLD cycle after a watchdog restart, so a restart replays the
   // same release timing as a cold start (which pays the synchroniser delay).
   logic                   arm, arm_n;

   logic rst_meta, rst_sync;
   logic ext_meta, ext_sync;

   // Saturating increment: counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // Reset release synchroniser: asserts asynchronously, releases after two edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_meta <= 1'b0;
         rst_sync <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_sync <= rst_meta;
      end
   end

   // External reset request synchroniser (level, asynchronous source).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ext_meta <= 1'b0;
         ext_sync <= 1'b0;
      end else begin
         ext_meta <= ext_rst_req;
         ext_sync <= ext_meta;
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_HOLD;
         hold_cnt  <= '0;
         gap_cnt   <= '0;
         run_cnt   <= '0;
         stage_idx <= '0;
         dom_rst   <= '1;
         all_rel   <= 1'b0;
         run_exp   <= 1'b0;
         arm       <= 1'b0;
      end else begin
         state     <= state_n;
         hold_cnt  <= hold_n;
         gap_cnt   <= gap_n;
         run_cnt   <= run_n;
         stage_idx <= idx_n;
         dom_rst   <= dom_n;
         all_rel   <= all_n;
         run_exp   <= exp_n;
         arm       <= arm_n;
      end
   end

   // Next-state logic; priority: pending reset release > ext > sw > expiry > advance.
   always_comb begin
      state_n = state;
      hold_n  = hold_cnt;
      gap_n   = gap_cnt;
      run_n   = run_cnt;
      idx_n   = stage_idx;
      dom_n   = dom_rst;
      all_n   = all_rel;
      exp_n   = run_exp;
      arm_n   = arm;

      if (!rst_sync || ext_sync || sw_rst_pulse) begin
         state_n = S_HOLD;
         hold_n  = '0;
         gap_n   = '0;
         run_n   = '0;
         idx_n   = '0;
         dom_n   = '1;
         all_n   = 1'b0;
         exp_n   = 1'b0;
         arm_n   = 1'b0;
      end else begin
         case (state)
            S_HOLD: begin
               if (arm) begin
                  arm_n = 1'b0;
               end else if (hold_cnt == HOLD_LAST) begin
                  // Domain 0 leaves reset on the same edge that ends HOLD.
                  dom_n[0] = 1'b0;
                  hold_n   = '0;
                  if (NUM_DOMAINS == 1) begin
                     state_n = S_RUN;
                     all_n   = 1'b1;
                     run_n   = '0;
                  end else begin
                     state_n = S_STAGE;
                     gap_n   = '0;
                     idx_n   = IDX_W'(1);
                  end
               end else begin
                  hold_n = sat_inc(hold_cnt);
               end
            end

            S_STAGE: begin
               if (gap_cnt == GAP_LAST) begin
                  for (int i = 0; i < NUM_DOMAINS; i++) begin
                     if (IDX_W'(i) == stage_idx) dom_n[i] = 1'b0;
                  end
                  gap_n = '0;
                  if (stage_idx == LAST_DOM) begin
                     state_n = S_RUN;
                     all_n   = 1'b1;
                     run_n   = '0;
                  end else begin
                     idx_n = stage_idx + IDX_W'(1);
                  end
               end else begin
                  gap_n = sat_inc(gap_cnt);
               end
            end

            S_RUN: begin
               if (RUN_CYCLES != 0 && run_cnt == RUN_LAST) begin
                  state_n = S_EXPIRED;
                  exp_n   = 1'b1;
`ifdef RSTSEQ_EXPIRE_RESTART_EN
                  dom_n   = '1;
                  all_n   = 1'b0;
`endif
               end else begin
                  run_n = sat_inc(run_cnt);
               end
            end

            S_EXPIRED: begin
`ifdef RSTSEQ_EXPIRE_RESTART_EN
               // Domains were re-asserted on entry; replay the whole sequence.
               state_n = S_HOLD;
               hold_n  = '0;
               gap_n   = '0;
               run_n   = '0;
               idx_n   = '0;
               arm_n   = 1'b1;
`else
               // Terminal: flag stays up, domains keep running.
               state_n = S_EXPIRED;
`endif
            end

            default: state_n = S_HOLD;
         endcase
      end
   end

   assign dom_rst_o      = dom_rst;
   assign all_released_o = all_rel;
   assign run_expired_o  = run_exp;
   assign state_o        = state;

endmodule

// File: tb/tb_sopc_reset_sequencer.sv
// Directed bench for sopc_reset_sequencer (HOLD=10, GAP=4, 2 domains, RUN=50, 20ns clock).
// Edge numbers are counted from the most recent rst release; obs packs
// {dom_rst_o[1:0], all_released_o, run_expired_o, state_o[1:0]}.
module tb_sopc_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       ext_rst_req;
   logic       sw_rst_pulse;
   logic [1:0] dom_rst_o;
   logic       all_released_o;
   logic       run_expired_o;
   logic [1:0] state_o;
   logic [5:0] obs;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int base     = 0;

   sopc_reset_sequencer #(
      .NUM_DOMAINS (2),
      .HOLD_CYCLES (10),
      .STAGE_GAP   (4),
      .RUN_CYCLES  (50),
      .CNT_W       (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ext_rst_req    (ext_rst_req),
      .sw_rst_pulse   (sw_rst_pulse),
      .dom_rst_o      (dom_rst_o),
      .all_released_o (all_released_o),
      .run_expired_o  (run_expired_o),
      .state_o        (state_o)
   );

   assign obs = {dom_rst_o, all_released_o, run_expired_o, state_o};

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Advance to 1ns after edge e (relative to the last rst release).
   task automatic goto_edge(input int e);
      while (cyc < base + e) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; ext_rst_req = 1'b0; sw_rst_pulse = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++; if (obs !== 6'b11_0_0_00) begin failures++; $display("FAIL rst_async got=%b want=%b", obs, 6'b11_0_0_00); end
      #97;
      checks++; if (obs !== 6'b11_0_0_00) begin failures++; $display("FAIL rst_held got=%b want=%b", obs, 6'b11_0_0_00); end
      #95 rst = 1'b1;
      base = cyc;
   endtask

   task automatic test_power_on(input string tag);
      goto_edge(11);
      checks++; if (obs !== 6'b11_0_0_00) begin failures++; $display("FAIL %s_e11 got=%b want=%b", tag, obs, 6'b11_0_0_00); end
      goto_edge(12);
      checks++; if (obs !== 6'b10_0_0_01) begin failures++; $display("FAIL %s_e12 got=%b want=%b", tag, obs, 6'b10_0_0_01); end
      goto_edge(15);
      checks++; if (obs !== 6'b10_0_0_01) begin failures++; $display("FAIL %s_e15 got=%b want=%b", tag, obs, 6'b10_0_0_01); end
      goto_edge(16);
      checks++; if (obs !== 6'b00_1_0_10) begin failures++; $display("FAIL %s_e16 got=%b want=%b", tag, obs, 6'b00_1_0_10); end
   endtask

   task automatic test_expiry;
      goto_edge(65);
      checks++; if (obs !== 6'b00_1_0_10) begin failures++; $display("FAIL exp_e65 got=%b want=%b", obs, 6'b00_1_0_10); end
`ifdef RSTSEQ_EXPIRE_RESTART_EN
      goto_edge(66);
      checks++; if (obs !== 6'b11_0_1_11) begin failures++; $display("FAIL exp_e66 got=%b want=%b", obs, 6'b11_0_1_11); end
      goto_edge(67);
      checks++; if (obs !== 6'b11_0_1_00) begin failures++; $display("FAIL exp_e67 got=%b want=%b", obs, 6'b11_0_1_00); end
      goto_edge(77);
      checks++; if (obs !== 6'b11_0_1_00) begin failures++; $display("FAIL exp_e77 got=%b want=%b", obs, 6'b11_0_1_00); end
      goto_edge(78);
      checks++; if (obs !== 6'b10_0_1_01) begin failures++; $display("FAIL exp_e78 got=%b want=%b", obs, 6'b10_0_1_01); end
`else
      goto_edge(66);
      checks++; if (obs !== 6'b00_1_1_11) begin failures++; $display("FAIL exp_e66 got=%b want=%b", obs, 6'b00_1_1_11); end
      goto_edge(70);
      checks++; if (obs !== 6'b00_1_1_11) begin failures++; $display("FAIL exp_e70 got=%b want=%b", obs, 6'b00_1_1_11); end
      goto_edge(78);
      checks++; if (obs !== 6'b00_1_1_11) begin failures++; $display("FAIL exp_e78 got=%b want=%b", obs, 6'b00_1_1_11); end
`endif
   endtask

   task automatic test_sw_reset;
      goto_edge(80);
      sw_rst_pulse = 1'b1;
      goto_edge(81);
      sw_rst_pulse = 1'b0;
      checks++; if (obs !== 6'b11_0_0_00) begin failures++; $display("FAIL sw_e81 got=%b want=%b", obs, 6'b11_0_0_00); end
   endtask

   // Second pulse mid-HOLD restarts the hold count: release moves from 91 to 96.
   task automatic test_sw_in_hold;
      goto_edge(85);
      sw_rst_pulse = 1'b1;
      goto_edge(86);
      sw_rst_pulse = 1'b0;
      goto_edge(91);
      checks++; if (obs !== 6'b11_0_0_00) begin failures++; $display("FAIL swh_e91 got=%b want=%b", obs, 6'b11_0_0_00); end
      goto_edge(95);
      checks++; if (obs !== 6'b11_0_0_00) begin failures++; $display("FAIL swh_e95 got=%b want=%b", obs, 6'b11_0_0_00); end
      goto_edge(96);
      checks++; if (obs !== 6'b10_0_0_01) begin failures++; $display("FAIL swh_e96 got=%b want=%b", obs, 6'b10_0_0_01); end
      goto_edge(100);
      checks++; if (obs !== 6'b00_1_0_10) begin failures++; $display("FAIL swh_e100 got=%b want=%b", obs, 6'b00_1_0_10); end
   endtask

   // ext raised after 105 takes effect at 108; dropped after 125, last forced HOLD at 127.
   task automatic test_ext_reset;
      goto_edge(105);
      ext_rst_req = 1'b1;
      goto_edge(107);
      checks++; if (obs !== 6'b00_1_0_10) begin failures++; $display("FAIL ext_e107 got=%b want=%b", obs, 6'b00_1_0_10); end
      for (int e = 108; e <= 127; e++) begin
         goto_edge(e);
         checks++; if (obs !== 6'b11_0_0_00) begin failures++; $display("FAIL ext_hold_e%0d got=%b want=%b", e, obs, 6'b11_0_0_00); end
         if (e == 125) ext_rst_req = 1'b0;
      end
      goto_edge(136);
      checks++; if (obs !== 6'b11_0_0_00) begin failures++; $display("FAIL ext_e136 got=%b want=%b", obs, 6'b11_0_0_00); end
      goto_edge(137);
      checks++; if (obs !== 6'b10_0_0_01) begin failures++; $display("FAIL ext_e137 got=%b want=%b", obs, 6'b10_0_0_01); end
      goto_edge(141);
      checks++; if (obs !== 6'b00_1_0_10) begin failures++; $display("FAIL ext_e141 got=%b want=%b", obs, 6'b00_1_0_10); end
   endtask

   // RUN began at 141 so expiry is due at 191; a sw pulse on that edge wins.
   task automatic test_sw_at_expiry;
      goto_edge(190);
      checks++; if (obs !== 6'b00_1_0_10) begin failures++; $display("FAIL swx_e190 got=%b want=%b", obs, 6'b00_1_0_10); end
      sw_rst_pulse = 1'b1;
      goto_edge(191);
      sw_rst_pulse = 1'b0;
      checks++; if (obs !== 6'b11_0_0_00) begin failures++; $display("FAIL swx_e191 got=%b want=%b", obs, 6'b11_0_0_00); end
      goto_edge(192);
      checks++; if (obs !== 6'b11_0_0_00) begin failures++; $display("FAIL swx_e192 got=%b want=%b", obs, 6'b11_0_0_00); end
   endtask

   // rst dropped mid-STAGE must assert every output before the next clock edge.
   task automatic test_async_reset;
      goto_edge(203);
      checks++; if (obs !== 6'b10_0_0_01) begin failures++; $display("FAIL ars_e203 got=%b want=%b", obs, 6'b10_0_0_01); end
      #4 rst = 1'b0;
      #1;
      checks++; if (obs !== 6'b11_0_0_00) begin failures++; $display("FAIL ars_async got=%b want=%b", obs, 6'b11_0_0_00); end
      #9 rst = 1'b1;
      base = cyc;
   endtask

   initial begin
      test_reset();
      test_power_on("pwr");
      test_expiry();
      test_sw_reset();
      test_sw_in_hold();
      test_ext_reset();
      test_sw_at_expiry();
      test_async_reset();
      test_power_on("repwr");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
